// File: rtl/key_debounce_ex.sv
// N-channel key conditioner: 2-FF sync, per-channel debounce, and
// press/release/long-press/auto-repeat event pulses.
module key_debounce_ex #(
    parameter int N          = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int DEB_CYC    = 480000,
    parameter int LONG_CYC   = 24000000,
    parameter int REP_CYC    = 4800000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_level,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_pulse,
    output logic [N-1:0] repeat_pulse
);

    localparam int HOLD_MAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
    localparam int DEB_W    = $clog2(DEB_CYC + 1);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic REL    = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_LONG = 2'd2
    } state_t;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [1:0]        sync;
        logic              p;
        logic [DEB_W-1:0]  deb_cnt, deb_nxt;
        logic              lvl, lvl_nxt;
        logic              rise, fall;
        state_t            state, state_nxt;
        logic [HOLD_W-1:0] hold_cnt, hold_nxt;
        logic              long_set, rep_set;
        logic              prs_q, rel_q, lng_q, rep_q;

        assign p    = REL ? ~sync[1] : sync[1];
        assign rise = lvl_nxt & ~lvl;
        assign fall = ~lvl_nxt & lvl;

        // Any sample agreeing with the accepted level restarts the count
        always_comb begin
            deb_nxt = '0;
            lvl_nxt = lvl;
            if (p != lvl) begin
                if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
                    lvl_nxt = p;
                end else begin
                    deb_nxt = deb_cnt + DEB_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync    <= {2{REL}};
                deb_cnt <= '0;
                lvl     <= 1'b0;
                prs_q   <= 1'b0;
                rel_q   <= 1'b0;
                lng_q   <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                sync    <= {sync[0], key[i]};
                deb_cnt <= deb_nxt;
                lvl     <= lvl_nxt;
                prs_q   <= rise;
                rel_q   <= fall;
                lng_q   <= long_set;
                rep_q   <= rep_set;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= S_IDLE;
                hold_cnt <= '0;
            end else begin
                state    <= state_nxt;
                hold_cnt <= hold_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            hold_nxt  = hold_cnt;
            unique case (state)
                S_IDLE: begin
                    if (rise) begin
                        state_nxt = S_HELD;
                        hold_nxt  = HOLD_W'(1);
                    end
                end
                S_HELD: begin
                    if (fall) begin
                        state_nxt = S_IDLE;
                        hold_nxt  = '0;
                    end else if (hold_cnt == HOLD_W'(LONG_CYC)) begin
                        state_nxt = S_LONG;
                        hold_nxt  = HOLD_W'(1);
                    end else begin
                        hold_nxt  = hold_cnt + HOLD_W'(1);
                    end
                end
                S_LONG: begin
                    if (fall) begin
                        state_nxt = S_IDLE;
                        hold_nxt  = '0;
                    end else if (hold_cnt == HOLD_W'(REP_CYC)) begin
                        hold_nxt  = HOLD_W'(1);
                    end else begin
                        hold_nxt  = hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    hold_nxt  = '0;
                end
            endcase
        end

        always_comb begin
            long_set = 1'b0;
            rep_set  = 1'b0;
            if (!fall) begin
                long_set = (state == S_HELD) &&
                           (hold_cnt == HOLD_W'(LONG_CYC));
                rep_set  = (state == S_LONG) &&
                           (hold_cnt == HOLD_W'(REP_CYC));
            end
        end

        assign key_level[i]     = lvl;
        assign press_pulse[i]   = prs_q;
        assign release_pulse[i] = rel_q;
        assign long_pulse[i]    = lng_q;
        assign repeat_pulse[i]  = rep_q;
    end

endmodule
